hdmi_text_axi_regs: RTL and testbench
=====================================

// Module: hdmi_text_axi_regs
// PURPOSE
//  AXI4-Lite responder that terminates the register/VRAM window of the HDMI text controller.
//  Accepts single-beat writes (with byte strobes) and reads from a bus master; stores NUM_REGS 32-bit words.
//  A second, independent read port lets the video/text-render side fetch words every pixel clock cycle.
//  Sits between the AXI interconnect and the text renderer; same clock domain as both.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  bus data width (only 32 supported)
//  C_S_AXI_ADDR_WIDTH  8   byte address width; word index = ADDR[ADDR_W-1:2]
//  NUM_REGS            16  number of implemented words; index >= NUM_REGS is out of range
// PORTS
//  ACLK           in   1     clock, all logic rising edge
//  ARESET         in   1     asynchronous, active-high reset
//  S_AXI_AWADDR   in   AW    write address      | S_AXI_AWPROT in 3 ignored
//  S_AXI_AWVALID  in   1     | S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32    write data         | S_AXI_WSTRB  in 4 byte enables
//  S_AXI_WVALID   in   1     | S_AXI_WREADY  out 1
//  S_AXI_BRESP    out  2     00 OKAY, 10 SLVERR | S_AXI_BVALID out 1 | S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   AW    read address       | S_AXI_ARPROT in 3 ignored
//  S_AXI_ARVALID  in   1     | S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32    | S_AXI_RRESP out 2 | S_AXI_RVALID out 1 | S_AXI_RREADY in 1
//  vid_addr       in   clog2(NUM_REGS)  render-side word index
//  vid_rdata      out  32    render-side data, 1-cycle latency
// BEHAVIOUR
//  Reset (async assert, sync-to-ACLK release): all words 0; AWREADY/WREADY/ARREADY=1; BVALID/RVALID=0;
//   BRESP/RRESP/RDATA/vid_rdata=0; any in-flight transaction discarded, no response issued.
//  Write channel FSM (W_IDLE, W_RESP):
//   - W_IDLE: AWREADY=1 until AW captured; WREADY=1 until W captured; AW and W may arrive in
//     either order or same cycle; each latched independently, ready drops once its half is held.
//   - When both halves held (incl. same-cycle arrival): commit on that edge, BVALID=1 next cycle,
//     goto W_RESP. Min latency AW/W handshake -> BVALID = 1 cycle.
//   - W_RESP: AWREADY=WREADY=0; BVALID held, BRESP stable until BREADY; then W_IDLE, readies=1.
//   - Commit: byte i of word updated iff WSTRB[i]; WSTRB=0 -> no change, BRESP=OKAY.
//   - Index >= NUM_REGS: no storage change, BRESP=SLVERR.
//  Read channel FSM (R_IDLE, R_DATA):
//   - R_IDLE: ARREADY=1. On handshake RDATA/RRESP registered from current contents, RVALID=1
//     next cycle, ARREADY=0, goto R_DATA.
//   - R_DATA: RDATA/RRESP held until RREADY; then RVALID=0, ARREADY=1 same edge.
//   - Index >= NUM_REGS: RDATA=0, RRESP=SLVERR.
//  Read/write channels fully independent; both may complete on the same edge.
//  Same-edge write commit and AR handshake to same word: read returns pre-write value.
//  ADDR[1:0] ignored (unaligned address treated as aligned word).
//  Render port: vid_rdata <= word[vid_addr] every edge; a write committing on edge N is visible
//   in vid_rdata after edge N+1. vid_addr >= NUM_REGS -> vid_rdata=0.
//  No outstanding-transaction queue: at most one write and one read in flight.
// STRUCTURE
//  Package hdmi_text_axi_pkg: RESP_OKAY/RESP_SLVERR localparams, wr_state_t {W_IDLE,W_RESP},
//   rd_state_t {R_IDLE,R_DATA}.
//  Sub-module hdmi_text_regbank: word array, byte-strobed write port, bus read port, render
//   read port, range check outputs. Top holds both channel FSMs and AXI output registers.
// TESTING
//  1 Reset: hold ARESET 200 ns -> all readies 1, valids 0; read 0x00..0x3C -> 0x00000000 OKAY.
//  2 Seq write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (WSTRB=F), then read back -> same data, OKAY.
//  3 AW two cycles before W, then W before AW, then same-cycle -> one BVALID each, data committed.
//  4 Write 0xAABBCCDD to 0x10, then 0x11223344 with WSTRB=0101 -> read 0x10 returns 0xAA22CC44.
//  5 Write/read 0x40 and 0xFC -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0; words 0..15 unchanged.
//  6 Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID, data stable; AWREADY/ARREADY stay 0.
//  7 Render port: write 0x55 to word 3, vid_addr=3 -> vid_rdata=0x55 two edges after commit.
//  8 ARESET mid-write (AW held, W pending) -> no BVALID, word unchanged, readies return to 1.

Source files
------------

// File: rtl/hdmi_text_axi_pkg.sv
// Shared response codes and channel state types for the HDMI text register window.
package hdmi_text_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/hdmi_text_regbank.sv
// Word storage for the HDMI text window: byte-strobed bus write, bus read and a
// registered render-side read port, plus range flags for the bus indices.
module hdmi_text_regbank #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 6,
    parameter int VID_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_widx,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    output logic                o_w_ok,
    input  logic [IDX_W-1:0]    i_ridx,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_r_ok,
    input  logic [VID_W-1:0]    i_vid_addr,
    output logic [DATA_W-1:0]   o_vid_rdata
);

    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_mem;
    logic [SEL_W-1:0]                w_wsel;
    logic [SEL_W-1:0]                w_rsel;
    logic                            w_vid_ok;

    assign o_w_ok   = 32'(i_widx) < 32'(NUM_REGS);
    assign o_r_ok   = 32'(i_ridx) < 32'(NUM_REGS);
    assign w_vid_ok = 32'(i_vid_addr) < 32'(NUM_REGS);
    assign w_wsel   = i_widx[SEL_W-1:0];
    assign w_rsel   = i_ridx[SEL_W-1:0];

    // Out-of-range bus reads return zero rather than an aliased word.
    assign o_rdata  = o_r_ok ? r_mem[w_rsel] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem       <= '0;
            o_vid_rdata <= '0;
        end else begin
            if (i_we && o_w_ok) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (i_wstrb[b]) r_mem[w_wsel][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            o_vid_rdata <= w_vid_ok ? r_mem[i_vid_addr] : '0;
        end
    end

endmodule

// File: rtl/hdmi_text_axi_regs.sv
// AXI4-Lite responder for the HDMI text register/VRAM window: independent write
// and read channel FSMs in front of the word bank, plus a render-side read port.
module hdmi_text_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS           = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [$clog2(NUM_REGS)-1:0]     vid_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   vid_rdata
);
    import hdmi_text_axi_pkg::*;

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW/8;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW-2;

    wr_state_t        r_wstate, w_wstate_nxt;
    logic             r_aw_held, r_w_held;
    logic [IDX_W-1:0] r_aw_idx;
    logic [DW-1:0]    r_wdata;
    logic [SW-1:0]    r_wstrb;
    logic [1:0]       r_bresp;
    logic             w_aw_fire, w_w_fire, w_commit, w_w_ok;
    logic [IDX_W-1:0] w_cm_idx;
    logic [DW-1:0]    w_cm_data;
    logic [SW-1:0]    w_cm_strb;

    rd_state_t        r_rstate, w_rstate_nxt;
    logic [DW-1:0]    r_rdata;
    logic [1:0]       r_rresp;
    logic             w_ar_fire, w_r_ok;
    logic [DW-1:0]    w_bank_rdata;

    logic             w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = (r_wstate == W_IDLE) && !r_aw_held;
    assign S_AXI_WREADY  = (r_wstate == W_IDLE) && !r_w_held;
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = (r_rstate == R_IDLE);
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    // Each half may already be latched or arriving this cycle; commit uses whichever is current.
    always_comb begin
        w_aw_fire    = S_AXI_AWVALID && S_AXI_AWREADY;
        w_w_fire     = S_AXI_WVALID && S_AXI_WREADY;
        w_cm_idx     = r_aw_held ? r_aw_idx : S_AXI_AWADDR[AW-1:2];
        w_cm_data    = r_w_held ? r_wdata : S_AXI_WDATA;
        w_cm_strb    = r_w_held ? r_wstrb : S_AXI_WSTRB;
        w_commit     = 1'b0;
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if ((r_aw_held || w_aw_fire) && (r_w_held || w_w_fire)) begin
                w_commit     = 1'b1;
                w_wstate_nxt = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= w_w_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[AW-1:2];
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
        end
    end

    always_comb begin
        w_ar_fire    = S_AXI_ARVALID && S_AXI_ARREADY;
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    // Sampled before any same-edge write lands, so a colliding read sees the old word.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_fire) begin
            r_rdata <= w_bank_rdata;
            r_rresp <= w_r_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    hdmi_text_regbank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DW),
        .IDX_W    (IDX_W),
        .VID_W    ($clog2(NUM_REGS))
    ) u_bank (
        .clk         (ACLK),
        .rst         (ARESET),
        .i_we        (w_commit),
        .i_widx      (w_cm_idx),
        .i_wdata     (w_cm_data),
        .i_wstrb     (w_cm_strb),
        .o_w_ok      (w_w_ok),
        .i_ridx      (S_AXI_ARADDR[AW-1:2]),
        .o_rdata     (w_bank_rdata),
        .o_r_ok      (w_r_ok),
        .i_vid_addr  (vid_addr),
        .o_vid_rdata (vid_rdata)
    );

endmodule

// File: tb/tb_hdmi_text_axi_regs.sv
// Self-checking bench for hdmi_text_axi_regs: table vectors, hand sequences for
// handshake corner cases, and random traffic against a word-array reference model.
module tb_hdmi_text_axi_regs;

    localparam int         NREG = 16;
    localparam logic [1:0] OK   = 2'b00;
    localparam logic [1:0] SLV  = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [7:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [3:0]  vid_addr = '0;
    logic [31:0] vid_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [NREG];

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] ed;
        logic [1:0]  er;
    } vec_t;

    vec_t tbl[$];

    hdmi_text_axi_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .vid_addr(vid_addr), .vid_rdata(vid_rdata)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, got no summary want summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: a byte-addressed window of NREG words; strobed bytes replace old ones.
    task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int          idx;
        logic [31:0] mask;
        idx  = int'(a) / 4;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (idx < NREG) begin
            model[idx] = (model[idx] & ~mask) | (d & mask);
            resp = OK;
        end else resp = SLV;
    endtask

    task automatic ref_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        if (idx < NREG) begin d = model[idx]; resp = OK; end
        else begin d = '0; resp = SLV; end
    endtask

    task automatic wait_b(input int stall, output logic [1:0] resp);
        int n = 0;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        chk("b_latency", n, 0);
        resp = S_AXI_BRESP;
        for (int i = 0; i < stall; i++) begin
            chk("b_hold_valid", S_AXI_BVALID, 1);
            chk("b_hold_resp", S_AXI_BRESP, resp);
            chk("b_hold_awready", S_AXI_AWREADY, 0);
            chk("b_hold_wready", S_AXI_WREADY, 0);
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        chk("b_done_valid", S_AXI_BVALID, 0);
        chk("b_done_awready", S_AXI_AWREADY, 1);
        chk("b_done_wready", S_AXI_WREADY, 1);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int stall,
                             output logic [1:0] resp);
        bit   awd = 0, wd = 0;
        int   cyc = 0;
        logic aw_rdy, w_rdy;
        @(posedge ACLK); #1;
        while (!(awd && wd) && cyc < 40) begin
            if (cyc == aw_dly && !awd) begin S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; end
            if (cyc == w_dly && !wd) begin S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; end
            @(negedge ACLK);
            aw_rdy = S_AXI_AWREADY;
            w_rdy  = S_AXI_WREADY;
            if (awd && !wd) chk("aw_ready_drop", aw_rdy, 0);
            if (wd && !awd) chk("w_ready_drop", w_rdy, 0);
            @(posedge ACLK); #1;
            if (S_AXI_AWVALID && aw_rdy) begin awd = 1; S_AXI_AWVALID = 1'b0; end
            if (S_AXI_WVALID && w_rdy) begin wd = 1; S_AXI_WVALID = 1'b0; end
            cyc++;
        end
        chk("w_handshake", {30'd0, awd, wd}, 3);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        wait_b(stall, resp);
    endtask

    task automatic axi_read(input logic [7:0] a, input int stall,
                            output logic [31:0] d, output logic [1:0] resp);
        int   n = 0;
        logic rdy;
        @(posedge ACLK); #1;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (S_AXI_ARVALID && n < 20) begin
            @(negedge ACLK); rdy = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (rdy) S_AXI_ARVALID = 1'b0;
            n++;
        end
        chk("ar_handshake", S_AXI_ARVALID, 0);
        S_AXI_ARVALID = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        chk("r_latency", n, 0);
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int i = 0; i < stall; i++) begin
            chk("r_hold_valid", S_AXI_RVALID, 1);
            chk("r_hold_data", S_AXI_RDATA, d);
            chk("r_hold_resp", S_AXI_RRESP, resp);
            chk("r_hold_arready", S_AXI_ARREADY, 0);
            @(negedge ACLK);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        chk("r_done_valid", S_AXI_RVALID, 0);
        chk("r_done_arready", S_AXI_ARREADY, 1);
    endtask

    task automatic scan(input string nm);
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < NREG; i++) begin
            axi_read(8'(i*4), 0, d, r);
            chk(nm, d, model[i]);
            chk({nm, "_resp"}, r, OK);
        end
    endtask

    initial begin
        logic [31:0] d, ed, old;
        logic [1:0]  r, er;
        logic [7:0]  a;

        for (int i = 0; i < NREG; i++) model[i] = '0;

        // reset
        #200;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_awready", S_AXI_AWREADY, 1);
        chk("rst_wready", S_AXI_WREADY, 1);
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_vid", vid_rdata, 0);
        scan("rst_scan");

        // table vectors
        tbl.push_back('{1, 8'h00, 32'h0000_0001, 4'hF, 32'h0, OK});
        tbl.push_back('{1, 8'h04, 32'h0000_0002, 4'hF, 32'h0, OK});
        tbl.push_back('{1, 8'h08, 32'h0000_0003, 4'hF, 32'h0, OK});
        tbl.push_back('{1, 8'h0C, 32'h0000_0004, 4'hF, 32'h0, OK});
        tbl.push_back('{0, 8'h00, 32'h0, 4'h0, 32'h0000_0001, OK});
        tbl.push_back('{0, 8'h04, 32'h0, 4'h0, 32'h0000_0002, OK});
        tbl.push_back('{0, 8'h08, 32'h0, 4'h0, 32'h0000_0003, OK});
        tbl.push_back('{0, 8'h0C, 32'h0, 4'h0, 32'h0000_0004, OK});
        tbl.push_back('{1, 8'h10, 32'hAABB_CCDD, 4'hF, 32'h0, OK});
        tbl.push_back('{1, 8'h10, 32'h1122_3344, 4'h5, 32'h0, OK});
        tbl.push_back('{0, 8'h10, 32'h0, 4'h0, 32'hAA22_CC44, OK});
        tbl.push_back('{1, 8'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, SLV});
        tbl.push_back('{1, 8'hFC, 32'hDEAD_BEEF, 4'hF, 32'h0, SLV});
        tbl.push_back('{0, 8'h40, 32'h0, 4'h0, 32'h0, SLV});
        tbl.push_back('{0, 8'hFC, 32'h0, 4'h0, 32'h0, SLV});
        tbl.push_back('{0, 8'h13, 32'h0, 4'h0, 32'hAA22_CC44, OK});
        tbl.push_back('{1, 8'h02, 32'hFFFF_FFFF, 4'h0, 32'h0, OK});
        tbl.push_back('{0, 8'h00, 32'h0, 4'h0, 32'h0000_0001, OK});
        tbl.push_back('{1, 8'h05, 32'h0000_BB00, 4'h2, 32'h0, OK});
        tbl.push_back('{0, 8'h04, 32'h0, 4'h0, 32'h0000_BB02, OK});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].a, tbl[i].d, tbl[i].s, 0, 0, 0, r);
                ref_write(tbl[i].a, tbl[i].d, tbl[i].s, er);
                chk($sformatf("tbl%0d_bresp", i), r, tbl[i].er);
            end else begin
                axi_read(tbl[i].a, 0, d, r);
                chk($sformatf("tbl%0d_rdata", i), d, tbl[i].ed);
                chk($sformatf("tbl%0d_rresp", i), r, tbl[i].er);
            end
        end
        scan("oor_scan");

        // AW/W ordering: AW first, W first, same cycle
        axi_write(8'h20, 32'hC0DE_0001, 4'hF, 0, 2, 0, r); ref_write(8'h20, 32'hC0DE_0001, 4'hF, er);
        chk("aw_first_bresp", r, er);
        axi_write(8'h24, 32'hC0DE_0002, 4'hF, 2, 0, 0, r); ref_write(8'h24, 32'hC0DE_0002, 4'hF, er);
        chk("w_first_bresp", r, er);
        axi_write(8'h28, 32'hC0DE_0003, 4'hF, 0, 0, 0, r); ref_write(8'h28, 32'hC0DE_0003, 4'hF, er);
        chk("same_cyc_bresp", r, er);
        for (int i = 8; i < 11; i++) begin
            axi_read(8'(i*4), 0, d, r);
            chk("order_rdata", d, model[i]);
        end

        // back-pressure on both response channels
        axi_write(8'h2C, 32'h5A5A_0F0F, 4'hF, 0, 0, 10, r); ref_write(8'h2C, 32'h5A5A_0F0F, 4'hF, er);
        chk("stall_bresp", r, er);
        axi_read(8'h2C, 10, d, r);
        chk("stall_rdata", d, 32'h5A5A_0F0F);
        axi_write(8'h44, 32'h1, 4'hF, 0, 0, 3, r);
        chk("stall_slverr", r, SLV);

        // same-edge write commit and read of the same word
        old = model[8];
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 8'h20; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 8'h20; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        chk("coll_bvalid", S_AXI_BVALID, 1);
        chk("coll_rvalid", S_AXI_RVALID, 1);
        chk("coll_rdata_old", S_AXI_RDATA, old);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        ref_write(8'h20, 32'h0BAD_F00D, 4'hF, er);
        @(negedge ACLK);
        chk("coll_bdone", S_AXI_BVALID, 0);
        chk("coll_rdone", S_AXI_RVALID, 0);
        axi_read(8'h20, 0, d, r);
        chk("coll_rdata_new", d, model[8]);

        // render port timing: new value visible only after the edge following commit
        old = model[3];
        vid_addr = 4'd3;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        chk("vid_before", vid_rdata, old);
        chk("vid_bvalid", S_AXI_BVALID, 1);
        @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        chk("vid_after", vid_rdata, 32'h0000_0055);
        ref_write(8'h0C, 32'h0000_0055, 4'hF, er);

        // reset with AW latched and W never sent
        @(posedge ACLK); #1 S_AXI_AWADDR = 8'h30; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        chk("mid_awready", S_AXI_AWREADY, 0);
        chk("mid_wready", S_AXI_WREADY, 1);
        @(posedge ACLK); #1 ARESET = 1'b1;
        #20;
        @(posedge ACLK); #1 ARESET = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("mid_no_bvalid", S_AXI_BVALID, 0);
            chk("mid_awready_back", S_AXI_AWREADY, 1);
            chk("mid_wready_back", S_AXI_WREADY, 1);
        end
        scan("mid_scan");

        // random traffic vs. reference model
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = 8'($urandom_range(0, 79));
                    d = $urandom;
                    axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                              $urandom_range(0, 2), 0, r);
                    ref_write(a, d, S_AXI_WSTRB, er);
                    chk("rnd_bresp", r, er);
                end
                1: begin
                    a = 8'($urandom_range(0, 79));
                    axi_read(a, 0, d, r);
                    ref_read(a, ed, er);
                    chk("rnd_rdata", d, ed);
                    chk("rnd_rresp", r, er);
                end
                default: begin
                    @(posedge ACLK); #1 vid_addr = 4'($urandom_range(0, NREG-1));
                    @(posedge ACLK);
                    @(negedge ACLK);
                    chk("rnd_vid", vid_rdata, model[vid_addr]);
                end
            endcase
        end
        scan("final_scan");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
